// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the IF->ID prefetch buffer.
// Holds default sizing, the nop encoding and the buffered entry record.
package fetch_queue_pkg;

   localparam int FQ_DEPTH  = 4;
   localparam int FQ_DATA_W = 32;
   localparam int FQ_ADDR_W = 32;

   localparam logic [FQ_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [FQ_ADDR_W-1:0] pc;
      logic [FQ_DATA_W-1:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the prefetch buffer.
// The queue uses the slave modport; the surrounding pipeline uses master.
interface fetch_queue_if
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH  = FQ_DEPTH,
   parameter int DATA_W = FQ_DATA_W,
   parameter int ADDR_W = FQ_ADDR_W
);

   logic [ADDR_W-1:0]            FetchPC;
   logic [DATA_W-1:0]            FetchInstr;
   logic                         FetchValid;
   logic                         Flush;
   logic                         PCStall;
   logic                         DecReady;
   logic                         DecValid;
   logic [DATA_W-1:0]            DecInstr;
   logic [ADDR_W-1:0]            DecPC;
   logic [ADDR_W-1:0]            DecPCPlus4;
   logic [$clog2(DEPTH+1)-1:0]   Count;

   modport master (
      output FetchPC, FetchInstr, FetchValid, Flush, DecReady,
      input  PCStall, DecValid, DecInstr, DecPC, DecPCPlus4, Count
   );

   modport slave (
      input  FetchPC, FetchInstr, FetchValid, Flush, DecReady,
      output PCStall, DecValid, DecInstr, DecPC, DecPCPlus4, Count
   );

endinterface

// File: rtl/fetch_queue_ptr_ctrl.sv
// Read/write pointers and occupancy for the prefetch buffer.
// Flush outranks both enqueue and dequeue; a full queue never enqueues.
module fetch_queue_ptr_ctrl
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_valid,
   input  logic             dec_ready,
   input  logic             flush,
   output logic [PTR_W-1:0] rptr,
   output logic [PTR_W-1:0] wptr,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             enq
);

   logic deq;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign enq   = fetch_valid && !full && !flush;
   assign deq   = !empty && dec_ready && !flush;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (flush) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (enq) wptr <= wptr + PTR_W'(1);
         if (deq) rptr <= rptr + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer between IF and ID: in-order {PC, instr} FIFO
// with PC back-pressure when full and a full discard on redirect.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH  = FQ_DEPTH,
   parameter int DATA_W = FQ_DATA_W,
   parameter int ADDR_W = FQ_ADDR_W
) (
   input  logic          Clk,
   input  logic          Reset,
   fetch_queue_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0] rptr;
   logic [PTR_W-1:0] wptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             enq;
   fq_entry_t        mem [DEPTH];
   fq_entry_t        head;

   fetch_queue_ptr_ctrl #(
      .DEPTH (DEPTH)
   ) u_ptr_ctrl (
      .clk         (Clk),
      .rst_n       (Reset),
      .fetch_valid (bus.FetchValid),
      .dec_ready   (bus.DecReady),
      .flush       (bus.Flush),
      .rptr        (rptr),
      .wptr        (wptr),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .enq         (enq)
   );

   // Entry contents need no reset: an empty queue gates them off the outputs.
   always_ff @(posedge Clk) begin
      if (enq) begin
         mem[wptr] <= '{pc: bus.FetchPC, instr: bus.FetchInstr};
      end
   end

   assign head = mem[rptr];

   assign bus.PCStall    = full;
   assign bus.Count      = count;
   assign bus.DecValid   = !empty;
   assign bus.DecInstr   = empty ? DATA_W'(NOP_INSTR) : head.instr;
   assign bus.DecPC      = empty ? '0 : head.pc;
   assign bus.DecPCPlus4 = empty ? '0 : head.pc + ADDR_W'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: fill, drain, streaming,
// flush, full-with-dequeue, async reset and PC+4 wrap.
module tb_fetch_queue;

   import fetch_queue_pkg::*;

   logic clock;
   logic reset;
   int   checkCount;
   int   failCount;

   fetch_queue_if #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) bus ();

   fetch_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) dut (
      .Clk   (clock),
      .Reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, take the edge, then settle 2ns past it.
   task automatic applyStimulus(input logic fv, input logic [31:0] pc,
                                input logic [31:0] instr, input logic ready,
                                input logic flush);
      bus.FetchValid = fv;
      bus.FetchPC    = pc;
      bus.FetchInstr = instr;
      bus.DecReady   = ready;
      bus.Flush      = flush;
      @(posedge clock);
      #2;
   endtask

   initial begin
      checkCount     = 0;
      failCount      = 0;
      reset          = 1'b0;
      bus.FetchValid = 1'b0;
      bus.FetchPC    = '0;
      bus.FetchInstr = '0;
      bus.DecReady   = 1'b0;
      bus.Flush      = 1'b0;

      #12;
      checkOutput("rst_count",    32'(bus.Count),    32'd0);
      checkOutput("rst_decvalid", 32'(bus.DecValid), 32'd0);
      checkOutput("rst_pcstall",  32'(bus.PCStall),  32'd0);
      checkOutput("rst_instr",    bus.DecInstr,      32'h0);
      @(posedge clock);
      #2 reset = 1'b1;

      $display("[TB] fill to full");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'(i*4), 32'h11 + 32'(i), 1'b0, 1'b0);
         checkOutput("fill_count",   32'(bus.Count),   32'(i+1));
         checkOutput("fill_pcstall", 32'(bus.PCStall), (i == 3) ? 32'd1 : 32'd0);
         checkOutput("fill_head",    bus.DecInstr,     32'h11);
      end
      applyStimulus(1'b1, 32'h10, 32'h15, 1'b0, 1'b0);
      checkOutput("full_count", 32'(bus.Count), 32'd4);
      checkOutput("full_instr", bus.DecInstr,   32'h11);
      checkOutput("full_pc",    bus.DecPC,      32'h0);
      checkOutput("full_pc4",   bus.DecPCPlus4, 32'h4);

      $display("[TB] drain");
      for (int k = 0; k < 4; k++) begin
         checkOutput("drain_instr", bus.DecInstr, 32'h11 + 32'(k));
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         checkOutput("drain_pcstall", 32'(bus.PCStall), 32'd0);
      end
      checkOutput("drain_valid", 32'(bus.DecValid), 32'd0);
      checkOutput("drain_instr0", bus.DecInstr,     32'h0);
      checkOutput("drain_pc0",   bus.DecPC,         32'h0);
      checkOutput("drain_count", 32'(bus.Count),    32'd0);

      $display("[TB] steady stream");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 32'h100 + 32'(4*i), 32'hA00 + 32'(i), 1'b1, 1'b0);
         checkOutput("stream_count",   32'(bus.Count),   32'd1);
         checkOutput("stream_pc",      bus.DecPC,        32'h100 + 32'(4*i));
         checkOutput("stream_instr",   bus.DecInstr,     32'hA00 + 32'(i));
         checkOutput("stream_pcstall", 32'(bus.PCStall), 32'd0);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("stream_end_count", 32'(bus.Count), 32'd0);

      $display("[TB] flush with enq and deq");
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 32'h200 + 32'(4*i), 32'hB0 + 32'(i), 1'b0, 1'b0);
      checkOutput("preflush_count", 32'(bus.Count), 32'd3);
      applyStimulus(1'b1, 32'h20C, 32'hBEEF, 1'b1, 1'b1);
      checkOutput("flush_count",   32'(bus.Count),    32'd0);
      checkOutput("flush_valid",   32'(bus.DecValid), 32'd0);
      checkOutput("flush_pcstall", 32'(bus.PCStall),  32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("postflush_valid", 32'(bus.DecValid), 32'd0);
      applyStimulus(1'b1, 32'h300, 32'hC0, 1'b0, 1'b0);
      checkOutput("redirect_pc",    bus.DecPC,    32'h300);
      checkOutput("redirect_instr", bus.DecInstr, 32'hC0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] full plus dequeue");
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 32'h400 + 32'(4*i), 32'hD0 + 32'(i), 1'b0, 1'b0);
      checkOutput("fd_pcstall_full", 32'(bus.PCStall), 32'd1);
      applyStimulus(1'b1, 32'h410, 32'hDD, 1'b1, 1'b0);
      checkOutput("fd_count",   32'(bus.Count),   32'd3);
      checkOutput("fd_pcstall", 32'(bus.PCStall), 32'd0);
      checkOutput("fd_pc",      bus.DecPC,        32'h404);
      for (int k = 0; k < 3; k++) begin
         checkOutput("fd_drain_instr", bus.DecInstr, 32'hD1 + 32'(k));
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      checkOutput("fd_drain_valid", 32'(bus.DecValid), 32'd0);

      $display("[TB] async reset mid-stream");
      applyStimulus(1'b1, 32'h500, 32'hE0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h504, 32'hE1, 1'b0, 1'b0);
      checkOutput("prerst_count", 32'(bus.Count), 32'd2);
      #1 reset = 1'b0;
      #1;
      checkOutput("arst_count",   32'(bus.Count),    32'd0);
      checkOutput("arst_valid",   32'(bus.DecValid), 32'd0);
      checkOutput("arst_pcstall", 32'(bus.PCStall),  32'd0);
      bus.FetchValid = 1'b0;
      @(posedge clock);
      #2 reset = 1'b1;
      applyStimulus(1'b1, 32'h0, 32'h77, 1'b0, 1'b0);
      checkOutput("resume_count", 32'(bus.Count), 32'd1);
      checkOutput("resume_pc",    bus.DecPC,      32'h0);
      checkOutput("resume_instr", bus.DecInstr,   32'h77);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] PC+4 wrap and idle ready");
      applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h99, 1'b0, 1'b0);
      checkOutput("wrap_pc",  bus.DecPC,      32'hFFFF_FFFC);
      checkOutput("wrap_pc4", bus.DecPCPlus4, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("idle_ready_count", 32'(bus.Count),    32'd0);
      checkOutput("idle_ready_valid", 32'(bus.DecValid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
